// File: rtl/alu_cmd_sequencer.sv
// Command/response sequencer for a 16-bit ALU: issues operands, waits a fixed
// settle time, captures result/error, and tracks accumulator, sticky errors and op count.
module alu_cmd_sequencer #(
  parameter int ALU_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_use_acc,
  input  logic             cmd_clr_err,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  input  logic [1:0]       alu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [2:0]       rsp_error,
  output logic [31:0]      acc,
  output logic [2:0]       sticky_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;

  localparam logic [3:0] CNT_LD = 4'(ALU_LAT - 1);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [15:0]      alu_a_q, alu_b_q;
  logic [3:0]       alu_op_q;
  logic [31:0]      rsp_result_q, acc_q;
  logic [2:0]       rsp_error_q, sticky_q;
  logic [CNT_W-1:0] op_count_q;
  logic [2:0]       sticky_d;
  logic             illegal_op;

  // A clear coinciding with a capture still keeps the newly captured error.
  assign sticky_d   = cmd_clr_err ? 3'b000 : sticky_q;
  assign illegal_op = (cmd_op == 4'd12) || (cmd_op == 4'd13);

  assign cmd_ready  = (state_q == IDLE) && reset;
  assign rsp_valid  = (state_q == DONE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign acc        = acc_q;
  assign sticky_err = sticky_q;
  assign op_count   = op_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= '0;
      acc_q        <= '0;
      sticky_q     <= '0;
      op_count_q   <= '0;
    end else begin
      sticky_q <= sticky_d;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (illegal_op) begin
              rsp_result_q <= '0;
              rsp_error_q  <= 3'b100;
              sticky_q     <= sticky_d | 3'b100;
              state_q      <= DONE;
            end else begin
              alu_a_q  <= cmd_use_acc ? acc_q[15:0] : cmd_a;
              alu_b_q  <= cmd_b;
              alu_op_q <= cmd_op;
              cnt_q    <= CNT_LD;
              state_q  <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (cnt_q == 4'd0) begin
            rsp_result_q <= alu_result;
            rsp_error_q  <= {1'b0, alu_error};
            sticky_q     <= sticky_d | {1'b0, alu_error};
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            if (rsp_error_q == 3'b000) acc_q <= rsp_result_q;
            op_count_q <= op_count_q + 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU on the alu_* pins.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic [3:0]  cmd_op = '0;
  logic        cmd_use_acc = 1'b0, cmd_clr_err = 1'b0;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_result, acc;
  logic [2:0]  rsp_error, sticky_err;
  logic [7:0]  op_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.ALU_LAT(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .cmd_use_acc(cmd_use_acc), .cmd_clr_err(cmd_clr_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .acc(acc), .sticky_err(sticky_err), .op_count(op_count)
  );

  // Behavioural ALU for the opcodes this bench exercises.
  always_comb begin
    alu_result = '0;
    alu_error  = '0;
    case (alu_op)
      4'd0: begin
        alu_result = {16'd0, alu_a} + {16'd0, alu_b};
        alu_error[0] = alu_result[16];
      end
      4'd1: alu_result = {16'd0, alu_a - alu_b};
      4'd2: alu_result = {16'd0, alu_a} * {16'd0, alu_b};
      4'd3: if (alu_b == 16'd0) alu_error[1] = 1'b1;
            else alu_result = {16'd0, alu_a / alu_b};
      4'd4: if (alu_b == 16'd0) alu_error[1] = 1'b1;
            else alu_result = {16'd0, alu_a % alu_b};
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents a command at the falling edge and returns just after the handshake edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                       input logic use_acc, input logic clr);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    cmd_use_acc = use_acc; cmd_clr_err = clr;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_use_acc = 1'b0; cmd_clr_err = 1'b0;
  endtask

  // Counts edges until rsp_valid, bounded so a dead DUT cannot hang the run.
  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'(n), 32'd0);
  endtask

  task automatic take_rsp;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;

    // Reset state
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_acc", acc, 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Basic add and latency
    issue(16'd15, 16'd126, 4'd0, 1'b0, 1'b0);
    chk("add_alu_a", 32'(alu_a), 32'd15);
    chk("add_alu_b", 32'(alu_b), 32'd126);
    chk("add_alu_op", 32'(alu_op), 32'd0);
    chk("add_cmd_ready", 32'(cmd_ready), 32'd0);
    wait_rsp(n);
    chk("add_latency", 32'(n), 32'd2);
    chk("add_result", rsp_result, 32'd141);
    chk("add_error", 32'(rsp_error), 32'd0);
    take_rsp();
    chk("add_acc", acc, 32'd141);
    chk("add_op_count", 32'(op_count), 32'd1);
    chk("add_idle_ready", 32'(cmd_ready), 32'd1);

    // Chained multiply then accumulate
    issue(16'd3, 16'd4, 4'd2, 1'b0, 1'b0);
    wait_rsp(n);
    chk("mul_result", rsp_result, 32'd12);
    take_rsp();
    chk("mul_acc", acc, 32'd12);
    issue(16'd999, 16'd5, 4'd0, 1'b1, 1'b0);
    chk("chain_alu_a", 32'(alu_a), 32'd12);
    wait_rsp(n);
    chk("chain_result", rsp_result, 32'd17);
    take_rsp();
    chk("chain_acc", acc, 32'd17);

    // Divide by zero
    issue(16'd100, 16'd0, 4'd3, 1'b0, 1'b0);
    wait_rsp(n);
    chk("div0_error", 32'(rsp_error), 32'd2);
    chk("div0_sticky", 32'(sticky_err), 32'd2);
    take_rsp();
    chk("div0_acc_kept", acc, 32'd17);
    chk("div0_op_count", 32'(op_count), 32'd4);

    // Illegal opcode with a simultaneous clear: capture wins over clear
    issue(16'd1, 16'd1, 4'd12, 1'b0, 1'b1);
    chk("ill_latency", 32'(rsp_valid), 32'd1);
    chk("ill_result", rsp_result, 32'd0);
    chk("ill_error", 32'(rsp_error), 32'd4);
    chk("ill_alu_op_kept", 32'(alu_op), 32'd3);
    chk("ill_sticky", 32'(sticky_err), 32'd4);
    take_rsp();
    chk("ill_op_count", 32'(op_count), 32'd5);
    chk("ill_acc_kept", acc, 32'd17);
    @(negedge clk); cmd_clr_err = 1'b1;
    @(posedge clk); #1; cmd_clr_err = 1'b0;
    chk("clr_sticky", 32'(sticky_err), 32'd0);

    // Backpressure with a queued command
    issue(16'd1, 16'd2, 4'd0, 1'b0, 1'b0);
    wait_rsp(n);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 16'd7; cmd_b = 16'd8; cmd_op = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_result", rsp_result, 32'd3);
      chk("bp_error", 32'(rsp_error), 32'd0);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_acc", acc, 32'd3);
    chk("bp_alu_a_before", 32'(alu_a), 32'd1);
    @(negedge clk); rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_queued_alu_a", 32'(alu_a), 32'd7);
    cmd_valid = 1'b0;
    wait_rsp(n);
    chk("bp_queued_result", rsp_result, 32'd15);
    take_rsp();
    chk("bp_op_count", 32'(op_count), 32'd7);

    // Asynchronous reset mid-SETTLE
    issue(16'd1, 16'd1, 4'd0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("ar_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("ar_alu_a", 32'(alu_a), 32'd0);
    chk("ar_acc", acc, 32'd0);
    chk("ar_op_count", 32'(op_count), 32'd0);
    chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("ar_rel_ready", 32'(cmd_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("ar_no_stale", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
